// File: rtl/api_ctrl.sv
// Host command engine: turns the SPI command byte stream into SDRAM requests, register file access and fill bursts.
// Outputs are registered one cycle after the strobe that causes them; fpga_irq is combinational; there is no backpressure.
module api_ctrl #(
    parameter int          ADDR_WIDTH = 22,
    parameter int          REG_COUNT  = 8,
    parameter int          FILL_GAP   = 8,
    parameter logic [15:0] VERSION    = 16'h0000
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic                  fpga_irq,
    output logic [31:0]           wr_reg,
    output logic [3:0]            wr_reg_addr,
    output logic                  wr_reg_changed,
    input  logic [31:0]           ev_reg,
    output logic                  ram_req,
    output logic                  ram_we,
    output logic [1:0]            ram_wm,
    output logic [ADDR_WIDTH-1:0] ram_address,
    output logic [15:0]           ram_data_write,
    input  logic [15:0]           ram_data_read,
    output logic                  ram_refresh,
    input  logic [7:0]            rd_data,
    input  logic                  rd_valid,
    output logic [7:0]            wr_data,
    input  logic                  wr_valid,
    input  logic                  start
);
    typedef enum logic [2:0] {S_IDLE, S_CMD, S_ADDR, S_DATA, S_FILL} state_t;

    localparam logic [2:0]  C_READ_MEM  = 3'd0;
    localparam logic [2:0]  C_WRITE_MEM = 3'd1;
    localparam logic [2:0]  C_READ_REG  = 3'd2;
    localparam logic [2:0]  C_WRITE_REG = 3'd3;
    localparam logic [15:0] GAP_RELOAD  = 16'(FILL_GAP - 1);

    state_t                state_q;
    logic [2:0]            cmd_q;
    logic [1:0]            byte_cnt_q;
    logic [31:0]           fld_q;
    logic [31:0]           shift_q;
    logic [31:0]           snap_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [7:0]            wbuf_q;
    logic [7:0]            rbuf_q;
    logic                  wpend_q;
    logic [15:0]           fill_pat_q;
    logic [15:0]           fill_cnt_q;
    logic [15:0]           gap_q;
    logic                  fill_fire_q;
    logic [31:0]           regs_q [REG_COUNT];

    logic                  ram_req_q;
    logic                  ram_we_q;
    logic [1:0]            ram_wm_q;
    logic [ADDR_WIDTH-1:0] ram_address_q;
    logic [15:0]           ram_data_write_q;
    logic                  ram_refresh_q;
    logic [7:0]            wr_data_q;
    logic [31:0]           wr_reg_q;
    logic [3:0]            wr_reg_addr_q;
    logic                  wr_reg_changed_q;

    logic [31:0]           fld_d;
    logic [31:0]           shift_d;
    logic [ADDR_WIDTH-1:0] hdr_addr;
    logic [3:0]            idx;
    logic [31:0]           rd_word;
    logic [7:0]            rd_byte;
    logic                  unused_bits;

    always_comb begin
        fld_d    = {fld_q[23:0], rd_data};
        shift_d  = {rd_data, shift_q[31:8]};
        hdr_addr = fld_d[ADDR_WIDTH:1];
        idx      = fld_q[3:0];
        rd_word  = '0;
        for (int i = 0; i < REG_COUNT; i++) begin
            if (idx == 4'(i)) rd_word = regs_q[i];
        end
        // Event register: first byte comes live, the rest from the snapshot taken on that byte.
        case (idx)
            4'd13:   rd_word = {31'd0, state_q == S_FILL};
            4'd14:   rd_word = (byte_cnt_q == 2'd0) ? ev_reg : snap_q;
            4'd15:   rd_word = {16'h0000, VERSION};
            default: ;
        endcase
        case (byte_cnt_q)
            2'd0:    rd_byte = rd_word[7:0];
            2'd1:    rd_byte = rd_word[15:8];
            2'd2:    rd_byte = rd_word[23:16];
            default: rd_byte = rd_word[31:24];
        endcase
    end

    assign unused_bits = ^{fld_q, fld_d, shift_q};

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q          <= S_IDLE;
            cmd_q            <= '0;
            byte_cnt_q       <= '0;
            fld_q            <= '0;
            shift_q          <= '0;
            snap_q           <= '0;
            addr_q           <= '0;
            wbuf_q           <= '0;
            rbuf_q           <= '0;
            wpend_q          <= 1'b0;
            fill_pat_q       <= '0;
            fill_cnt_q       <= '0;
            gap_q            <= '0;
            fill_fire_q      <= 1'b0;
            for (int i = 0; i < REG_COUNT; i++) regs_q[i] <= '0;
            ram_req_q        <= 1'b0;
            ram_we_q         <= 1'b0;
            ram_wm_q         <= '0;
            ram_address_q    <= '0;
            ram_data_write_q <= '0;
            ram_refresh_q    <= 1'b0;
            wr_data_q        <= '0;
            wr_reg_q         <= '0;
            wr_reg_addr_q    <= '0;
            wr_reg_changed_q <= 1'b0;
        end else begin
            ram_req_q     <= 1'b0;
            ram_refresh_q <= fill_fire_q;
            fill_fire_q   <= 1'b0;
            if (start) begin
                state_q    <= S_CMD;
                byte_cnt_q <= '0;
                fill_cnt_q <= '0;
                wpend_q    <= 1'b0;
                // A dangling low byte of a memory write goes out alone with the high byte masked.
                if (wpend_q) begin
                    ram_req_q        <= 1'b1;
                    ram_we_q         <= 1'b1;
                    ram_wm_q         <= 2'b10;
                    ram_address_q    <= addr_q;
                    ram_data_write_q <= {8'h00, wbuf_q};
                end
            end else begin
                case (state_q)
                    S_CMD: if (rd_valid) begin
                        cmd_q      <= rd_data[2:0];
                        byte_cnt_q <= '0;
                        fld_q      <= '0;
                        state_q    <= (rd_data <= 8'd4) ? S_ADDR : S_IDLE;
                    end
                    S_ADDR: if (rd_valid) begin
                        fld_q      <= fld_d;
                        byte_cnt_q <= byte_cnt_q + 2'd1;
                        if (byte_cnt_q == 2'd0) ram_refresh_q <= 1'b1;
                        if (byte_cnt_q == 2'd3) begin
                            addr_q     <= hdr_addr;
                            byte_cnt_q <= '0;
                            state_q    <= S_DATA;
                            if (cmd_q == C_READ_MEM) begin
                                ram_req_q     <= 1'b1;
                                ram_we_q      <= 1'b0;
                                ram_address_q <= hdr_addr;
                            end
                        end
                    end
                    S_DATA: begin
                        case (cmd_q)
                            C_READ_MEM: if (wr_valid) begin
                                byte_cnt_q <= byte_cnt_q + 2'd1;
                                if (!byte_cnt_q[0]) begin
                                    wr_data_q     <= ram_data_read[7:0];
                                    rbuf_q        <= ram_data_read[15:8];
                                    addr_q        <= addr_q + 1'b1;
                                    ram_req_q     <= 1'b1;
                                    ram_we_q      <= 1'b0;
                                    ram_address_q <= addr_q + 1'b1;
                                end else begin
                                    wr_data_q     <= rbuf_q;
                                    ram_refresh_q <= 1'b1;
                                end
                            end
                            C_WRITE_MEM: if (rd_valid) begin
                                byte_cnt_q <= byte_cnt_q + 2'd1;
                                if (!byte_cnt_q[0]) begin
                                    wbuf_q        <= rd_data;
                                    wpend_q       <= 1'b1;
                                    ram_refresh_q <= 1'b1;
                                end else begin
                                    wpend_q          <= 1'b0;
                                    ram_req_q        <= 1'b1;
                                    ram_we_q         <= 1'b1;
                                    ram_wm_q         <= 2'b00;
                                    ram_address_q    <= addr_q;
                                    ram_data_write_q <= {rd_data, wbuf_q};
                                    addr_q           <= addr_q + 1'b1;
                                end
                            end
                            C_READ_REG: if (wr_valid) begin
                                wr_data_q  <= rd_byte;
                                byte_cnt_q <= byte_cnt_q + 2'd1;
                                if (byte_cnt_q == 2'd0 && idx == 4'd14) snap_q <= ev_reg;
                                if (byte_cnt_q == 2'd3) state_q <= S_IDLE;
                            end
                            C_WRITE_REG: if (rd_valid) begin
                                shift_q    <= shift_d;
                                byte_cnt_q <= byte_cnt_q + 2'd1;
                                if (byte_cnt_q == 2'd3) begin
                                    wr_reg_q         <= shift_d;
                                    wr_reg_addr_q    <= idx;
                                    wr_reg_changed_q <= ~wr_reg_changed_q;
                                    for (int i = 0; i < REG_COUNT; i++) begin
                                        if (idx == 4'(i)) regs_q[i] <= shift_d;
                                    end
                                    state_q <= S_IDLE;
                                end
                            end
                            default: if (rd_valid) begin
                                shift_q    <= shift_d;
                                byte_cnt_q <= byte_cnt_q + 2'd1;
                                if (byte_cnt_q == 2'd3) begin
                                    fill_pat_q <= shift_d[15:0];
                                    fill_cnt_q <= shift_d[31:16];
                                    gap_q      <= '0;
                                    state_q    <= S_FILL;
                                end
                            end
                        endcase
                    end
                    S_FILL: begin
                        if (fill_cnt_q == 16'd0) begin
                            state_q <= S_IDLE;
                        end else if (gap_q == 16'd0) begin
                            ram_req_q        <= 1'b1;
                            ram_we_q         <= 1'b1;
                            ram_wm_q         <= 2'b00;
                            ram_address_q    <= addr_q;
                            ram_data_write_q <= fill_pat_q;
                            addr_q           <= addr_q + 1'b1;
                            fill_cnt_q       <= fill_cnt_q - 16'd1;
                            gap_q            <= GAP_RELOAD;
                            fill_fire_q      <= 1'b1;
                        end else begin
                            gap_q <= gap_q - 16'd1;
                        end
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign fpga_irq       = (snap_q != ev_reg);
    assign wr_reg         = wr_reg_q;
    assign wr_reg_addr    = wr_reg_addr_q;
    assign wr_reg_changed = wr_reg_changed_q;
    assign ram_req        = ram_req_q;
    assign ram_we         = ram_we_q;
    assign ram_wm         = ram_wm_q;
    assign ram_address    = ram_address_q;
    assign ram_data_write = ram_data_write_q;
    assign ram_refresh    = ram_refresh_q;
    assign wr_data        = wr_data_q;

endmodule
